// File: rtl/adder_frame_sequencer.sv
// adder_frame_sequencer: feeds lane beats to an external adder tree and accumulates its
// pipelined sums into one frame total, tracking beat count and overflow.
module adder_frame_sequencer #(
    parameter int NUM_INPUT = 4,
    parameter int WIDTH_IN  = 16,
    parameter int IS_SIGNED = 1,
    parameter int ADD_DELAY = 1,
    parameter int MAX_BEATS = 16,
    localparam int SUM_W = WIDTH_IN + $clog2(NUM_INPUT),
    localparam int ACC_W = SUM_W + $clog2(MAX_BEATS),
    localparam int CNT_W = $clog2(MAX_BEATS + 1)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_s_valid,
    output logic                                o_s_ready,
    input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  i_s_data,
    input  logic                                i_s_last,
    output logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  o_add_data,
    output logic                                o_add_ena,
    input  logic [SUM_W-1:0]                    i_add_sum,
    output logic                                o_m_valid,
    input  logic                                i_m_ready,
    output logic [ACC_W-1:0]                    o_m_sum,
    output logic [CNT_W-1:0]                    o_m_beats,
    output logic                                o_m_ovf,
    output logic                                o_busy
);
    localparam int TW = 2 * (ADD_DELAY > 0 ? ADD_DELAY : 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tag_q, tag_d;
    logic [ACC_W-1:0]  acc_q, acc_d, m_sum_q, m_sum_d, sum_ext;
    logic [CNT_W-1:0]  cnt_q, cnt_d, m_beats_q, m_beats_d;
    logic              ovf_q, ovf_d, m_ovf_q, m_ovf_d;
    logic              accept, full, em_v, em_l;
    logic [1:0]        new_tag, em_tag;

    always_comb begin
        o_s_ready  = (state_q == IDLE || state_q == RUN) && !i_rst;
        accept     = i_s_valid && o_s_ready;
        o_add_ena  = state_q != DONE;
        o_add_data = accept ? i_s_data : '0;
        new_tag    = {accept, accept && i_s_last};
        // ADD_DELAY=0 means the adder is combinational, so the tag emerges with its beat
        em_tag     = ADD_DELAY == 0 ? new_tag : tag_q[TW-1 -: 2];
        em_v       = em_tag[1] && o_add_ena;
        em_l       = em_tag[0] && em_v;
        sum_ext    = IS_SIGNED != 0 ? ACC_W'(signed'(i_add_sum)) : ACC_W'(i_add_sum);
        full       = cnt_q == CNT_W'(MAX_BEATS);
        tag_d      = o_add_ena ? TW'({tag_q, new_tag}) : tag_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        m_sum_d    = m_sum_q;
        m_beats_d  = m_beats_q;
        m_ovf_d    = m_ovf_q;
        state_d    = state_q;
        if (em_v) begin
            acc_d = acc_q + sum_ext;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
            ovf_d = ovf_q || full;
        end
        // results include the final beat's sum; running state restarts for the next frame
        if (em_l) begin
            m_sum_d   = acc_d;
            m_beats_d = cnt_d;
            m_ovf_d   = ovf_d;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
        end
        case (state_q)
            IDLE, RUN: state_d = em_l ? DONE : (accept && i_s_last) ? DRAIN : accept ? RUN : state_q;
            DRAIN:     state_d = em_l ? DONE : DRAIN;
            default:   state_d = i_m_ready ? IDLE : DONE;
        endcase
        o_m_valid = state_q == DONE;
        o_busy    = state_q != IDLE;
        o_m_sum   = m_sum_q;
        o_m_beats = m_beats_q;
        o_m_ovf   = m_ovf_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            m_sum_q   <= '0;
            m_beats_q <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            m_sum_q   <= m_sum_d;
            m_beats_q <= m_beats_d;
            m_ovf_q   <= m_ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_frame_sequencer.sv
// tb_adder_frame_sequencer: directed frames against a 2-stage adder-tree model,
// scoreboard queue of hand-computed results checked by an output monitor.
module tb_adder_frame_sequencer;
    localparam int NI = 4, WI = 8, AD = 2, MB = 16;
    localparam int SUM_W = 10, ACC_W = 14, CNT_W = 5;

    typedef struct packed {
        logic [ACC_W-1:0] s;
        logic [CNT_W-1:0] b;
        logic             o;
    } exp_t;

    logic                    i_clk = 0, i_rst = 1, i_s_valid = 0, i_s_last = 0, i_m_ready = 1;
    logic [NI-1:0][WI-1:0]   i_s_data = '0;
    logic [NI-1:0][WI-1:0]   o_add_data;
    logic [SUM_W-1:0]        i_add_sum;
    logic                    o_s_ready, o_add_ena, o_m_valid, o_m_ovf, o_busy;
    logic [ACC_W-1:0]        o_m_sum;
    logic [CNT_W-1:0]        o_m_beats;
    logic signed [SUM_W-1:0] p1, p2, lane_sum;
    exp_t                    q[$];
    int                      n_cmp = 0, n_bad = 0;

    adder_frame_sequencer #(
        .NUM_INPUT(NI), .WIDTH_IN(WI), .IS_SIGNED(1), .ADD_DELAY(AD), .MAX_BEATS(MB)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_s_data(i_s_data), .i_s_last(i_s_last), .o_add_data(o_add_data),
        .o_add_ena(o_add_ena), .i_add_sum(i_add_sum), .o_m_valid(o_m_valid),
        .i_m_ready(i_m_ready), .o_m_sum(o_m_sum), .o_m_beats(o_m_beats),
        .o_m_ovf(o_m_ovf), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // external adder tree: signed lane sum, two enabled register stages
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NI; i++) lane_sum = lane_sum + SUM_W'(signed'(o_add_data[i]));
    end
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p1 <= '0;
            p2 <= '0;
        end else if (o_add_ena) begin
            p1 <= lane_sum;
            p2 <= p1;
        end
    end
    assign i_add_sum = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_m_valid && i_m_ready) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("m_sum", 32'(o_m_sum), 32'(e.s));
                chk("m_beats", 32'(o_m_beats), 32'(e.b));
                chk("m_ovf", 32'(o_m_ovf), 32'(e.o));
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic last);
        chk("s_ready_on_beat", 32'(o_s_ready), 1);
        i_s_valid = 1;
        i_s_data  = d;
        i_s_last  = last;
        @(posedge i_clk);
        #1;
        i_s_valid = 0;
        i_s_last  = 0;
        i_s_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // called just after the last beat's accepting edge; valid must appear after 2 more edges
    task automatic wait_valid(input string nm);
        int k = 0;
        @(negedge i_clk);
        while (!o_m_valid && k < 20) begin
            @(posedge i_clk);
            k++;
            @(negedge i_clk);
        end
        chk(nm, k, 2);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, 32'(o_m_valid), 0);
        chk({nm, "_sum"}, 32'(o_m_sum), 0);
        chk({nm, "_beats"}, 32'(o_m_beats), 0);
        chk({nm, "_ovf"}, 32'(o_m_ovf), 0);
        chk({nm, "_busy"}, 32'(o_busy), 0);
        chk({nm, "_add_data"}, 32'(o_add_data), 0);
    endtask

    initial begin
        logic [ACC_W-1:0] s0;
        logic [CNT_W-1:0] b0;
        #13;
        check_reset_outputs("rst_init");
        #10 i_rst = 0;
        idle(1);
        chk("ready_after_rst", 32'(o_s_ready), 1);
        chk("busy_after_rst", 32'(o_busy), 0);

        // back-to-back: 10 + 20 - 4 = 26
        q.push_back('{s: 14'd26, b: 5'd3, o: 1'b0});
        beat({8'd4, 8'd3, 8'd2, 8'd1}, 0);
        chk("busy_in_run", 32'(o_busy), 1);
        beat(32'h05050505, 0);
        beat(32'hFFFFFFFF, 1);
        chk("ready_in_drain", 32'(o_s_ready), 0);
        wait_valid("latency_b2b");
        idle(1);

        // same frame with two idle cycles between beats
        q.push_back('{s: 14'd26, b: 5'd3, o: 1'b0});
        beat({8'd4, 8'd3, 8'd2, 8'd1}, 0);
        idle(2);
        beat(32'h05050505, 0);
        idle(2);
        beat(32'hFFFFFFFF, 1);
        wait_valid("latency_gaps");
        idle(1);

        // consumer stalls: 100 - 20 = 80, held for 5 cycles
        i_m_ready = 0;
        q.push_back('{s: 14'd80, b: 5'd2, o: 1'b0});
        beat({8'd40, 8'd30, 8'd20, 8'd10}, 0);
        beat(32'hFBFBFBFB, 1);
        wait_valid("latency_stall");
        s0 = 14'd80;
        b0 = 5'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("hold_valid", 32'(o_m_valid), 1);
            chk("hold_sum", 32'(o_m_sum), 32'(s0));
            chk("hold_beats", 32'(o_m_beats), 32'(b0));
            chk("hold_ovf", 32'(o_m_ovf), 0);
            chk("hold_s_ready", 32'(o_s_ready), 0);
        end
        @(posedge i_clk);
        #1 i_m_ready = 1;
        @(negedge i_clk);
        chk("done_s_ready", 32'(o_s_ready), 0);
        @(posedge i_clk);
        #1;
        chk("idle_after_ready", 32'(o_busy), 0);
        q.push_back('{s: 14'd4, b: 5'd1, o: 1'b0});
        beat(32'h01010101, 1);
        wait_valid("latency_single");
        idle(1);

        // reset mid-clock during DRAIN discards the frame
        beat({8'd4, 8'd3, 8'd2, 8'd1}, 0);
        beat(32'h05050505, 1);
        #3 i_rst = 1;
        #1;
        check_reset_outputs("rst_drain");
        chk("rst_drain_ready", 32'(o_s_ready), 0);
        #7 i_rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            chk("no_valid_after_rst", 32'(o_m_valid), 0);
        end
        chk("ready_after_rst2", 32'(o_s_ready), 1);
        chk("busy_after_rst2", 32'(o_busy), 0);
        @(posedge i_clk);
        #1;
        q.push_back('{s: 14'd508, b: 5'd1, o: 1'b0});
        beat(32'h7F7F7F7F, 1);
        wait_valid("latency_508");
        idle(1);

        // exactly MAX_BEATS: 16 * 508 = 8128, no overflow
        q.push_back('{s: 14'd8128, b: 5'd16, o: 1'b0});
        for (int i = 0; i < 16; i++) beat(32'h7F7F7F7F, i == 15);
        wait_valid("latency_16");
        idle(1);

        // 17 beats: 8636 wraps to -7748 in 14 bits, beats saturate, overflow flagged
        q.push_back('{s: 14'(-7748), b: 5'd16, o: 1'b1});
        for (int i = 0; i < 17; i++) beat(32'h7F7F7F7F, i == 16);
        wait_valid("latency_17");
        idle(3);

        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
